// File: rtl/cdc_tx_arbiter.sv
// Round-robin arbiter that shares the source port of a 4-phase CDC handshake channel
// among G_N_REQ requesters, holding the captured word stable until the channel completes.
module cdc_tx_arbiter #(
    parameter int G_N_REQ = 4,
    parameter int G_WIDTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_enable,
    input  logic [G_N_REQ-1:0]           i_valid,
    input  logic [G_N_REQ*G_WIDTH-1:0]   i_data,
    output logic [G_N_REQ-1:0]           o_accept,
    output logic [G_N_REQ-1:0]           o_done,
    output logic                         o_ready,
    output logic [G_WIDTH-1:0]           o_data,
    input  logic                         i_busy,
    output logic [$clog2(G_N_REQ)-1:0]   o_grant_id,
    output logic                         o_active,
    output logic [15:0]                  o_xfer_count
);

    localparam int IDW = $clog2(G_N_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE
    } state_t;

    state_t               state_q;
    logic [IDW-1:0]       last_q;
    logic [IDW-1:0]       grant_id_q;
    logic [G_WIDTH-1:0]   data_q;
    logic [G_N_REQ-1:0]   accept_q;
    logic [G_N_REQ-1:0]   done_q;
    logic                 ready_q;
    logic                 active_q;
    logic [15:0]          xfer_cnt_q;

    logic                 win_found_d;
    logic [IDW-1:0]       win_idx_d;
    logic [G_WIDTH-1:0]   win_word_d;
    int                   cand;
    logic [IDW-1:0]       cand_idx;

    // Search upward from the requester after the last completed one, wrapping around.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < G_N_REQ; i++) begin
            cand = int'(last_q) + 1 + i;
            if (cand >= G_N_REQ) begin
                cand = cand - G_N_REQ;
            end
            cand_idx = IDW'(cand);
            if (!win_found_d && i_valid[cand_idx]) begin
                win_found_d = 1'b1;
                win_idx_d   = cand_idx;
            end
        end
    end

    always_comb begin
        win_word_d = '0;
        for (int k = 0; k < G_N_REQ; k++) begin
            if (IDW'(k) == win_idx_d) begin
                win_word_d = i_data[k*G_WIDTH +: G_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            last_q     <= IDW'(G_N_REQ - 1);
            grant_id_q <= '0;
            data_q     <= '0;
            accept_q   <= '0;
            done_q     <= '0;
            ready_q    <= 1'b0;
            active_q   <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            accept_q <= '0;
            done_q   <= '0;
            case (state_q)
                S_IDLE: begin
                    // A busy channel in IDLE is still initialising; simply wait.
                    if (i_enable && !i_busy && win_found_d) begin
                        data_q     <= win_word_d;
                        grant_id_q <= win_idx_d;
                        accept_q   <= G_N_REQ'(1) << win_idx_d;
                        ready_q    <= 1'b1;
                        active_q   <= 1'b1;
                        state_q    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (i_busy) begin
                        ready_q <= 1'b0;
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_busy) begin
                        done_q     <= G_N_REQ'(1) << grant_id_q;
                        last_q     <= grant_id_q;
                        xfer_cnt_q <= xfer_cnt_q + 16'd1;
                        active_q   <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_accept     = accept_q;
    assign o_done       = done_q;
    assign o_ready      = ready_q;
    assign o_data       = data_q;
    assign o_grant_id   = grant_id_q;
    assign o_active     = active_q;
    assign o_xfer_count = xfer_cnt_q;

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Scoreboard bench for cdc_tx_arbiter with a behavioural 4-phase channel on the A side.
module tb_cdc_tx_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [N-1:0]  valid;
    logic [N*W-1:0] data;
    logic [N-1:0]  o_accept;
    logic [N-1:0]  o_done;
    logic          o_ready;
    logic [W-1:0]  o_data;
    logic          busy;
    logic [1:0]    o_grant_id;
    logic          o_active;
    logic [15:0]   o_xfer_count;

    logic          ch_busy;
    logic          busy_ovr;
    logic [W-1:0]  b_data;
    int            ch_cnt;
    int            hold_cyc;

    typedef struct {
        int         id;
        logic [W-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend_q[$];
    exp_t e_mon;
    exp_t p_mon;

    int          n_vec;
    int          n_err;
    int          ready_cnt;
    logic [15:0] exp_cnt;

    cdc_tx_arbiter #(.G_N_REQ(N), .G_WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (enable),
        .i_valid      (valid),
        .i_data       (data),
        .o_accept     (o_accept),
        .o_done       (o_done),
        .o_ready      (o_ready),
        .o_data       (o_data),
        .i_busy       (busy),
        .o_grant_id   (o_grant_id),
        .o_active     (o_active),
        .o_xfer_count (o_xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign busy = ch_busy | busy_ovr;

    // Channel model: latch data on ready, stay busy hold_cyc cycles and until ready drops.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_busy <= 1'b0;
            b_data  <= '0;
            ch_cnt  <= 0;
        end else if (!ch_busy) begin
            if (o_ready) begin
                ch_busy <= 1'b1;
                b_data  <= o_data;
                ch_cnt  <= hold_cyc;
            end
        end else if (ch_cnt > 0) begin
            ch_cnt <= ch_cnt - 1;
        end else if (!o_ready) begin
            ch_busy <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if ((o_accept != '0) || (o_done != '0)) begin
                chk("acc_onehot", {31'd0, $onehot0(o_accept)}, 1);
                chk("done_onehot", {31'd0, $onehot0(o_done)}, 1);
                chk("acc_done_overlap", {28'd0, o_accept & o_done}, 0);
            end
            if (o_accept != '0) begin
                ready_cnt = 0;
                if (exp_q.size() == 0) begin
                    chk("unexp_accept", {28'd0, o_accept}, 0);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("accept_vec", {28'd0, o_accept}, 32'd1 << e_mon.id);
                    chk("grant_id", {30'd0, o_grant_id}, e_mon.id);
                    chk("accept_data", {28'd0, o_data}, {28'd0, e_mon.d});
                    pend_q.push_back(e_mon);
                end
            end else if (o_active && pend_q.size() > 0) begin
                chk("data_stable", {28'd0, o_data}, {28'd0, pend_q[0].d});
            end
            if (o_ready) ready_cnt++;
            if (o_done != '0) begin
                if (pend_q.size() == 0) begin
                    chk("unexp_done", {28'd0, o_done}, 0);
                end else begin
                    p_mon = pend_q.pop_front();
                    exp_cnt = exp_cnt + 16'd1;
                    chk("done_vec", {28'd0, o_done}, 32'd1 << p_mon.id);
                    chk("done_data", {28'd0, o_data}, {28'd0, p_mon.d});
                    chk("b_data", {28'd0, b_data}, {28'd0, p_mon.d});
                    chk("xfer_count", {16'd0, o_xfer_count}, {16'd0, exp_cnt});
                    chk("ready_cycles", ready_cnt, 2);
                end
            end
        end
    end

    task automatic push_exp(input int id, input logic [W-1:0] d);
        exp_t t;
        t.id = id;
        t.d  = d;
        exp_q.push_back(t);
    endtask

    task automatic wait_ev(input bit want_done, input string tag);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (want_done ? (o_done != '0) : (o_accept != '0)) return;
        end
        chk(tag, 0, 1);
    endtask

    task automatic wait_launch_over();
        for (int n = 0; n < 50; n++) begin
            if (!o_ready) return;
            @(negedge clk);
        end
        chk("launch_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        pend_q.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        ready_cnt = 0;
        exp_cnt = '0;
        rst = 1'b1;
        enable = 1'b1;
        valid = '0;
        data = '0;
        busy_ovr = 1'b0;
        hold_cyc = 2;
        repeat (3) @(negedge clk);
        chk("rst_accept", {28'd0, o_accept}, 0);
        chk("rst_done", {28'd0, o_done}, 0);
        chk("rst_ready", {31'd0, o_ready}, 0);
        chk("rst_data", {28'd0, o_data}, 0);
        chk("rst_grant", {30'd0, o_grant_id}, 0);
        chk("rst_active", {31'd0, o_active}, 0);
        chk("rst_count", {16'd0, o_xfer_count}, 0);
        rst = 1'b0;
        @(negedge clk);

        // single request
        push_exp(0, 4'hA);
        data[3:0] = 4'hA;
        valid = 4'b0001;
        @(negedge clk);
        chk("accept_latency", {28'd0, o_accept}, 1);
        valid = '0;
        wait_ev(1, "done_timeout");
        chk("count_after_one", {16'd0, o_xfer_count}, 1);

        // all four requesting continuously
        do_reset();
        data = {4'h4, 4'h3, 4'h2, 4'h1};
        push_exp(0, 4'h1);
        push_exp(1, 4'h2);
        push_exp(2, 4'h3);
        push_exp(3, 4'h4);
        push_exp(0, 4'h1);
        valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ev(0, "accept_timeout");
            if (i == 4) valid = '0;
            wait_ev(1, "done_timeout");
        end
        chk("rr_queue_empty", exp_q.size(), 0);

        // data stability after accept
        push_exp(0, 4'h7);
        data[3:0] = 4'h7;
        valid = 4'b0001;
        wait_ev(0, "accept_timeout");
        data[3:0] = 4'hF;
        valid = '0;
        wait_ev(1, "done_timeout");

        // busy during IDLE blocks grants
        busy_ovr = 1'b1;
        push_exp(1, 4'h5);
        data[7:4] = 4'h5;
        valid = 4'b0010;
        repeat (5) begin
            @(negedge clk);
            chk("blocked_by_busy", {27'd0, o_active, o_accept}, 0);
        end
        busy_ovr = 1'b0;
        wait_ev(0, "accept_timeout");
        valid = '0;
        wait_ev(1, "done_timeout");

        // enable dropped during WAIT_DONE
        push_exp(2, 4'h6);
        data[11:8] = 4'h6;
        valid = 4'b0100;
        wait_ev(0, "accept_timeout");
        valid = '0;
        @(negedge clk);
        wait_launch_over();
        enable = 1'b0;
        data[15:12] = 4'h9;
        valid = 4'b1000;
        wait_ev(1, "done_timeout");
        repeat (6) begin
            @(negedge clk);
            chk("blocked_by_enable", {27'd0, o_active, o_accept}, 0);
        end
        push_exp(3, 4'h9);
        enable = 1'b1;
        wait_ev(0, "accept_timeout");
        valid = '0;
        wait_ev(1, "done_timeout");

        // async reset during WAIT_DONE
        hold_cyc = 10;
        push_exp(2, 4'hC);
        data[11:8] = 4'hC;
        valid = 4'b0100;
        wait_ev(0, "accept_timeout");
        valid = '0;
        @(negedge clk);
        wait_launch_over();
        @(negedge clk);
        chk("in_wait_done", {30'd0, o_active, o_ready}, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_active", {31'd0, o_active}, 0);
        chk("arst_ready", {31'd0, o_ready}, 0);
        chk("arst_data", {28'd0, o_data}, 0);
        chk("arst_grant", {30'd0, o_grant_id}, 0);
        chk("arst_count", {16'd0, o_xfer_count}, 0);
        chk("arst_done", {28'd0, o_done}, 0);
        pend_q.delete();
        exp_q.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        hold_cyc = 2;
        repeat (3) begin
            @(negedge clk);
            chk("no_done_after_rst", {28'd0, o_done}, 0);
        end
        data = {4'hD, 4'hC, 4'hB, 4'hA};
        push_exp(0, 4'hA);
        valid = 4'b1111;
        wait_ev(0, "accept_timeout");
        valid = '0;
        wait_ev(1, "done_timeout");

        // counter wrap
        @(negedge clk);
        force dut.xfer_cnt_q = 16'hFFFE;
        #1;
        release dut.xfer_cnt_q;
        exp_cnt = 16'hFFFE;
        push_exp(1, 4'h3);
        data[7:4] = 4'h3;
        valid = 4'b0010;
        wait_ev(0, "accept_timeout");
        valid = '0;
        wait_ev(1, "done_timeout");
        chk("count_ffff", {16'd0, o_xfer_count}, 32'hFFFF);
        push_exp(1, 4'h8);
        data[7:4] = 4'h8;
        valid = 4'b0010;
        wait_ev(0, "accept_timeout");
        valid = '0;
        wait_ev(1, "done_timeout");
        chk("count_wrap", {16'd0, o_xfer_count}, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdc_tx_arbiter.md
# cdc_tx_arbiter

Round-robin arbiter and sequencer that shares the source (A-domain) port of one 4-phase CDC handshake channel among `G_N_REQ` requesters in the same clock domain. It captures the winning requester's word and drives the channel's ready/data inputs. It holds the data stable for the whole handshake, watches the channel's busy flag to detect completion, and returns per-requester accept/done pulses. It sits entirely in clock domain A, between the requester logic and the CDC channel.

## Interface

Parameters:
- `G_N_REQ`, 4: number of requesters; ≥2.
- `G_WIDTH`, 4: data width; must equal the CDC channel width.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `i_clk`  in  1  domain-A clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_enable`  in  1  global enable; 0 blocks new grants but never aborts a transfer in flight.
- `i_valid`  in  G_N_REQ  per-requester request; held with data until `o_accept` bit.
- `i_data`  in  G_N_REQ*G_WIDTH  requester words; requester k occupies bits [k*G_WIDTH +: G_WIDTH].
- `o_accept`  out  G_N_REQ  one-cycle pulse: word captured, requester may drop/change valid and data.
- `o_done`  out  G_N_REQ  one-cycle pulse: channel handshake for that requester's word completed.
- `o_ready`  out  1  to channel ready input.
- `o_data`  out  G_WIDTH  to channel data input; stable from grant until completion.
- `i_busy`  in  1  from channel busy output.
- `o_grant_id`  out  $clog2(G_N_REQ)  index of current/last granted requester.
- `o_active`  out  1  transfer in flight (state ≠ IDLE).
- `o_xfer_count`  out  16  completed transfers, wraps 0xFFFF→0x0000.

## Operation

- FSM states: IDLE, LAUNCH, WAIT_DONE.
- **IDLE:**
  - Grant condition: `i_enable`=1, `i_busy`=0 and any `i_valid` bit set.
  - Winner selection: the first set bit searching from `(last+1) mod G_N_REQ` upward, with wrap-around.
  - On grant, register `o_data`←winner's word, `o_grant_id`←winner, `o_accept[winner]`←1 for one cycle, `o_ready`←1, and go to LAUNCH.
- **LAUNCH:**
  - Hold `o_ready`=1 until `i_busy` is sampled 1.
  - Then drive `o_ready`←0 and go to WAIT_DONE.
- **WAIT_DONE:**
  - On `i_busy` sampled 0, pulse `o_done[o_grant_id]`, set `last`←`o_grant_id`, increment `o_xfer_count`, and go to IDLE.
- `i_busy`=1 while in IDLE (channel still in reset or initialising) blocks grants; it is not an error.
- `i_valid` bits of non-winners are ignored during a transfer and arbitrated at the next IDLE.
- Dropping `i_valid` before accept withdraws the request; no pulse is issued for it.
- `o_data` changes only at grant. `i_data` changes after accept must not reach `o_data`.
- Reset values:
  - State=IDLE, `last`=G_N_REQ-1 (requester 0 has first priority).
  - `o_ready`=0, `o_data`=0, `o_accept`=0, `o_done`=0.
  - `o_grant_id`=0, `o_active`=0, `o_xfer_count`=0.
- Reset mid-transfer: all state clears immediately and no `o_done` is issued. The CDC channel shares this reset and must be reset together.
- One-hot guarantee: at most one `o_accept` bit and at most one `o_done` bit set per cycle, never both in the same cycle.
- All outputs are registered.

## Timing

- **Grant:** valid & !busy sampled at edge k → `o_accept`, `o_ready`=1, `o_data` valid after edge k.
- **Launch hand-off:** the channel samples ready at edge k+1 and raises busy. The arbiter samples busy=1 at edge k+2, so `o_ready`=0 after k+2. `o_ready` is high for exactly 2 cycles with an immediately responsive channel.
- **Completion:** `o_done` is asserted the cycle after the edge that samples `i_busy` falling.
- **Back-to-back:** the next grant is at the earliest edge after `o_done`, so there is a minimum 1 IDLE cycle between transfers.
- **Latency:** accept-to-done is 2 cycles plus the channel handshake duration; it is unbounded if the channel stalls (no timeout).

## Test plan

- **Reset then single request:** after reset, `i_valid`=0001, data0=0xA, `i_busy` low.
  - `o_accept`=0001 one cycle later; `o_data`=0xA; `o_ready` high 2 cycles with a model channel.
  - `o_done`=0001 when busy falls; `o_xfer_count`=1.
- **All four requesting continuously** with distinct data 0x1..0x4:
  - Grant order is 0,1,2,3,0.
  - Each `o_data` matches its requester.
  - Exactly one accept and one done per transfer; no overlap.
- **Data stability:** change `i_data` of the granted requester to 0xF right after `o_accept`.
  - `o_data` stays at the original value until `o_done`.
  - Channel B-side output equals the original value.
- **Blocking conditions:**
  - Hold `i_busy`=1 from the channel during IDLE with `i_valid`=0010: no grant until busy falls, then accept requester 1.
  - `i_enable`=0 during WAIT_DONE: the current transfer completes with done, and no new grant occurs until enable returns to 1.
- **Async reset mid-WAIT_DONE:** assert `i_rst` between clock edges.
  - Outputs go to reset values immediately; no `o_done`.
  - Requester 0 is granted first after release.
- **Counter wrap:** preload via 65535 transfers (or force); the next completion gives `o_xfer_count`=0x0000.
